step_gen: RTL and testbench

STEP_GEN -- requirements
Module: step_gen

---
 rtl/step_gen.sv | 178 +++++++++++++++++
 tb/tb_step_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_gen.sv
// Step/direction pulse generator: a phase accumulator sets the step rate, and
// each step is a fixed-width pulse followed by a minimum low gap.
module step_gen #(
  parameter int unsigned PULSE_LEN = 100,
  parameter int unsigned DIR_SETUP = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_velocity,
  input  logic [31:0] in_steps,
  input  logic        load_stb,
  input  logic        abort_stb,
  input  logic        pos_set_stb,
  input  logic [31:0] in_position,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done_stb,
  output logic        overrun,
  output logic [31:0] position
);

  localparam int unsigned CNT_MAX   = (PULSE_LEN > DIR_SETUP) ? PULSE_LEN : DIR_SETUP;
  localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit          HAS_SETUP = (DIR_SETUP != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_PULSE,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mag;
  logic [31:0]   acc;
  logic [31:0]   remaining;
  logic          pending;
  logic          abort_lat;

  logic [32:0]   acc_sum;
  logic          evt;
  logic [31:0]   vel_mag;
  logic [31:0]   pos_next;
  logic          pulse_end;
  logic          setup_end;

  // Carry out of the 32-bit phase accumulator is the step request.
  assign acc_sum   = {1'b0, acc} + {1'b0, mag};
  assign evt       = acc_sum[32];
  assign vel_mag   = in_velocity[31] ? (~in_velocity + 32'd1) : in_velocity;
  assign pos_next  = dir ? (position - 32'd1) : (position + 32'd1);
  assign pulse_end = (cnt == CW'(PULSE_LEN - 1));
  assign setup_end = (cnt == CW'(DIR_SETUP - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mag       <= '0;
      acc       <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      abort_lat <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      done_stb  <= 1'b0;
      overrun   <= 1'b0;
      position  <= '0;
    end else begin
      done_stb <= 1'b0;
      if (state == S_RUN || state == S_PULSE || state == S_GAP) begin
        acc <= acc_sum[31:0];
      end
      // A second request while one is already queued behind the current pulse is lost.
      if ((state == S_PULSE || state == S_GAP) && evt) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (pos_set_stb) position <= in_position;
          if (load_stb && !abort_stb) begin
            if (in_steps == 32'd0) begin
              done_stb <= 1'b1;
            end else begin
              mag       <= vel_mag;
              remaining <= in_steps;
              acc       <= '0;
              pending   <= 1'b0;
              abort_lat <= 1'b0;
              overrun   <= 1'b0;
              cnt       <= '0;
              busy      <= 1'b1;
              if (in_velocity[31] != dir) begin
                dir   <= in_velocity[31];
                state <= HAS_SETUP ? S_SETUP : S_RUN;
              end else begin
                state <= S_RUN;
              end
            end
          end
        end

        S_SETUP: begin
          if (abort_stb) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done_stb <= 1'b1;
          end else if (setup_end) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_RUN: begin
          if (abort_stb) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done_stb <= 1'b1;
          end else if (evt) begin
            state     <= S_PULSE;
            step      <= 1'b1;
            position  <= pos_next;
            remaining <= remaining - 32'd1;
            cnt       <= '0;
          end
        end

        S_PULSE: begin
          if (abort_stb) abort_lat <= 1'b1;
          if (pulse_end) begin
            state <= S_GAP;
            step  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_GAP: begin
          if (abort_stb) abort_lat <= 1'b1;
          if (pulse_end) begin
            cnt <= '0;
            if (remaining == 32'd0 || abort_lat || abort_stb) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              done_stb <= 1'b1;
            end else if (pending || evt) begin
              state     <= S_PULSE;
              step      <= 1'b1;
              position  <= pos_next;
              remaining <= remaining - 32'd1;
              pending   <= 1'b0;
            end else begin
              state <= S_RUN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          step  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_gen.sv
// Bench for step_gen: per-cycle waveform compared with a timeline model built
// from step-event times of the phase accumulator.
module tb_step_gen;

  localparam int unsigned PL   = 4;
  localparam int unsigned DS   = 2;
  localparam int          MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_velocity;
  logic [31:0] in_steps;
  logic        load_stb;
  logic        abort_stb;
  logic        pos_set_stb;
  logic [31:0] in_position;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done_stb;
  logic        overrun;
  logic [31:0] position;

  step_gen #(.PULSE_LEN(PL), .DIR_SETUP(DS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_velocity (in_velocity),
    .in_steps    (in_steps),
    .load_stb    (load_stb),
    .abort_stb   (abort_stb),
    .pos_set_stb (pos_set_stb),
    .in_position (in_position),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .done_stb    (done_stb),
    .overrun     (overrun),
    .position    (position)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_dir;
  logic [31:0] m_pos;
  logic        m_ovr;

  bit exp_step [MAXC+2];
  int exp_done;
  int exp_pulses;
  int exp_first;
  bit exp_ovr;

  // Accumulation cycle c (counting from 'first') carries when floor(n*mag/2^32) increments.
  function automatic bit is_evt(input logic [31:0] mag, input int first, input int c);
    longint unsigned n;
    if (c < first) return 1'b0;
    n = longint'(c - first + 1);
    return ((n * 64'(mag)) >> 32) != (((n - 64'd1) * 64'(mag)) >> 32);
  endfunction

  // Cycle 1 is the first cycle after the load edge. A pulse starting at s occupies
  // s..s+2PL-1; any event inside queues the next pulse at s+2PL, a second one is lost.
  task automatic build_model(input logic [31:0] mag, input int steps, input int first,
                             input int abort_cyc);
    int cur, s, e, nev;
    bit ab, fin, again;
    for (int k = 0; k < MAXC + 2; k++) exp_step[k] = 1'b0;
    exp_pulses = 0;
    exp_ovr    = 1'b0;
    exp_done   = MAXC;
    exp_first  = 0;
    cur        = 1;
    fin        = 1'b0;
    while (!fin && cur < MAXC) begin
      e = 0;
      for (int t = cur; t < MAXC && e == 0 && !fin; t++) begin
        if (t == abort_cyc) begin
          exp_done = t + 1;
          fin      = 1'b1;
        end else if (is_evt(mag, first, t)) begin
          e = t;
        end
      end
      if (fin || e == 0) begin
        fin = 1'b1;
      end else begin
        s     = e + 1;
        again = 1'b1;
        while (again) begin
          if (exp_first == 0) exp_first = s;
          for (int k = s; k < s + int'(PL); k++) if (k < MAXC + 2) exp_step[k] = 1'b1;
          exp_pulses++;
          nev = 0;
          ab  = 1'b0;
          for (int t = s; t < s + 2 * int'(PL); t++) begin
            if (is_evt(mag, first, t)) nev++;
            if (t == abort_cyc) ab = 1'b1;
          end
          if (nev >= 2) exp_ovr = 1'b1;
          if (exp_pulses == steps || ab) begin
            exp_done = s + 2 * int'(PL);
            fin      = 1'b1;
            again    = 1'b0;
          end else if (nev >= 1) begin
            s = s + 2 * int'(PL);
          end else begin
            cur   = s + 2 * int'(PL);
            again = 1'b0;
          end
        end
      end
    end
  endtask

  // abort_mode: 0 none, 1 absolute cycle, 2 offset from first pulse start, 3 random.
  task automatic run_move(input string name, input logic [31:0] vel, input logic [31:0] steps,
                          input bit preset, input logic [31:0] pval,
                          input int abort_mode, input int abort_val, input bit busy_junk);
    logic [31:0] mag;
    logic        dir_new;
    int          first, abort_cyc;
    logic [3:0]  obs, expv;
    mag       = vel[31] ? (~vel + 32'd1) : vel;
    abort_cyc = 0;
    if (preset) m_pos = pval;
    if (steps == 32'd0) begin
      for (int k = 0; k < MAXC + 2; k++) exp_step[k] = 1'b0;
      exp_done   = 1;
      exp_pulses = 0;
      dir_new    = m_dir;
    end else begin
      dir_new = vel[31];
      first   = (dir_new != m_dir) ? int'(DS) + 1 : 1;
      if (abort_mode == 1) begin
        abort_cyc = abort_val;
      end else if (abort_mode == 2) begin
        build_model(mag, int'(steps), first, 0);
        abort_cyc = exp_first + abort_val;
      end else if (abort_mode == 3) begin
        build_model(mag, int'(steps), first, 0);
        abort_cyc = $urandom_range(exp_done - 1, 1);
      end
      build_model(mag, int'(steps), first, abort_cyc);
    end

    @(negedge clk);
    in_velocity = vel;
    in_steps    = steps;
    in_position = pval;
    load_stb    = 1'b1;
    pos_set_stb = preset;
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      expv = {dir_new, exp_step[k], (k < exp_done), (k == exp_done)};
      obs  = {dir, step, busy, done_stb};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d {dir,step,busy,done} got %b expected %b", name, k, obs, expv);
      end
      load_stb    = 1'b0;
      pos_set_stb = 1'b0;
      abort_stb   = (k == abort_cyc);
      if (busy_junk && k == 3 && k < exp_done) begin
        load_stb    = 1'b1;
        pos_set_stb = 1'b1;
        in_position = $urandom;
        in_velocity = $urandom;
        in_steps    = 32'd7;
      end
    end
    abort_stb = 1'b0;

    m_dir = dir_new;
    if (steps != 32'd0) begin
      m_pos = dir_new ? (m_pos - 32'(exp_pulses)) : (m_pos + 32'(exp_pulses));
      m_ovr = exp_ovr;
    end
    checks++;
    if (position !== m_pos) begin
      errors++;
      $display("FAIL %s position got %h expected %h", name, position, m_pos);
    end
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("FAIL %s overrun got %b expected %b", name, overrun, m_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_velocity = '0; in_steps = '0; in_position = '0;
    load_stb = 1'b0; abort_stb = 1'b0; pos_set_stb = 1'b0;
    m_dir = 1'b0; m_pos = '0; m_ovr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({step, dir, busy, done_stb, overrun, position} !== 37'd0) begin
      errors++;
      $display("FAIL reset outputs got %b_%b_%b_%b_%b_%h expected all zero",
               step, dir, busy, done_stb, overrun, position);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_move("basic", 32'h1000_0000, 32'd3, 1'b0, '0, 0, 0, 1'b0);
    checks++;
    if (position !== 32'd3 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_final position %h overrun %b expected 3 and 0", position, overrun);
    end
  endtask

  task automatic test_dir_change();
    run_move("dir_change", 32'hF000_0000, 32'd2, 1'b0, '0, 0, 0, 1'b0);
    checks++;
    if (position !== 32'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL dir_change_final position %h dir %b expected 1 and 1", position, dir);
    end
  endtask

  task automatic test_zero_steps();
    run_move("zero_steps", 32'h1000_0000, 32'd0, 1'b0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_abort_pulse();
    run_move("abort_pulse", 32'h1000_0000, 32'd3, 1'b0, '0, 2, 1, 1'b0);
    checks++;
    if (position !== 32'd2) begin
      errors++;
      $display("FAIL abort_pulse_final position got %h expected 2", position);
    end
  endtask

  task automatic test_overrun();
    run_move("overrun", 32'h8000_0000, 32'd10, 1'b1, 32'd20, 0, 0, 1'b0);
    checks++;
    if (position !== 32'd10 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_final position %h overrun %b expected 10 and 1", position, overrun);
    end
  endtask

  task automatic test_wrap();
    run_move("wrap", 32'hC000_0000, 32'd1, 1'b1, 32'd0, 0, 0, 1'b0);
    checks++;
    if (position !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_final position got %h expected ffffffff", position);
    end
  endtask

  task automatic test_mag_zero();
    run_move("mag_zero", 32'd0, 32'd5, 1'b0, '0, 1, 12, 1'b0);
  endtask

  task automatic test_idle_strobes();
    logic [31:0] pv;
    @(negedge clk);
    in_velocity = 32'h1000_0000;
    in_steps    = 32'd5;
    load_stb    = 1'b1;
    abort_stb   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      load_stb  = 1'b0;
      abort_stb = 1'b0;
      checks++;
      if ({step, busy, done_stb} !== 3'b000) begin
        errors++;
        $display("FAIL load_with_abort cycle %0d {step,busy,done} got %b expected 000",
                 k, {step, busy, done_stb});
      end
    end
    pv          = $urandom;
    in_position = pv;
    pos_set_stb = 1'b1;
    @(negedge clk);
    pos_set_stb = 1'b0;
    m_pos       = pv;
    checks++;
    if (position !== pv) begin
      errors++;
      $display("FAIL pos_set position got %h expected %h", position, pv);
    end
  endtask

  task automatic test_random();
    logic [31:0] mag, vel, steps, pval;
    int          pick;
    for (int i = 0; i < 14; i++) begin
      mag   = $urandom_range(32'h8000_0000, 32'h0400_0000);
      vel   = ($urandom_range(1, 0) == 1) ? (~mag + 32'd1) : mag;
      steps = 32'($urandom_range(6, 1));
      pick  = $urandom_range(3, 0);
      pval  = (pick == 0) ? 32'd0 : (pick == 1) ? 32'h7FFF_FFFF :
              (pick == 2) ? 32'hFFFF_FFFF : $urandom;
      run_move("random", vel, steps, 1'($urandom_range(1, 0)), pval,
               ($urandom_range(2, 0) == 0) ? 3 : 0, 0, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    @(negedge clk);
    in_velocity = 32'h1000_0000;
    in_steps    = 32'd3;
    load_stb    = 1'b1;
    seen        = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      load_stb = 1'b0;
      seen     = (step === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_reset_wait step got %b expected 1 within 100 cycles", step);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({step, busy, position} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset step %b busy %b position %h expected 0 0 0", step, busy, position);
    end
    @(negedge clk);
    rst   = 1'b1;
    m_dir = 1'b0;
    m_pos = '0;
    m_ovr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dir_change();
    test_zero_steps();
    test_abort_pulse();
    test_overrun();
    test_wrap();
    test_mag_zero();
    test_idle_strobes();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
